// File: rtl/seq10110_pkg.sv
// Shared types and constants for the 10110 serial pattern detector.
package seq10110_pkg;

   typedef enum logic [2:0] {
      M0 = 3'd0,
      M1 = 3'd1,
      M2 = 3'd2,
      M3 = 3'd3,
      M4 = 3'd4
   } mealy_state_e;

   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4,
      S5 = 3'd5
   } moore_state_e;

   typedef enum logic {
      StyleMoore = 1'b0,
      StyleMealy = 1'b1
   } fsm_style_e;

   localparam logic [4:0]  PATTERN     = 5'b10110;
   localparam int unsigned PATTERN_LEN = 5;

endpackage

// File: rtl/seq10110_fsm_core.sv
// One 10110 detector FSM; Style picks a Moore (registered flag) or Mealy (state && !j) output.
module seq10110_fsm_core
   import seq10110_pkg::*;
#(
   parameter fsm_style_e Style = StyleMoore
) (
   input  logic clk,
   input  logic rst,
   input  logic j,
   output logic detect
);

   if (Style == StyleMealy) begin : g_mealy
      mealy_state_e state;

      always_ff @(posedge clk) begin
         if (rst) begin
            state <= M0;
         end else begin
            case (state)
               M0:      state <= j ? M1 : M0;
               M1:      state <= j ? M1 : M2;
               M2:      state <= j ? M3 : M0;
               M3:      state <= j ? M4 : M2;
               M4:      state <= j ? M1 : M2;
               default: state <= M0;
            endcase
         end
      end

      // Combinational on purpose: follows j immediately while in M4.
      assign detect = (state == M4) && !j;

   end else begin : g_moore
      moore_state_e state;
      logic         detect_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            state    <= S0;
            detect_q <= 1'b0;
         end else begin
            detect_q <= 1'b0;
            case (state)
               S0:      state <= j ? S1 : S0;
               S1:      state <= j ? S1 : S2;
               S2:      state <= j ? S3 : S0;
               S3:      state <= j ? S4 : S2;
               S4: begin
                  if (j) begin
                     state <= S1;
                  end else begin
                     state    <= S5;
                     detect_q <= 1'b1;
                  end
               end
               S5:      state <= j ? S3 : S0;
               default: state <= S0;
            endcase
         end
      end

      // Flag is registered alongside the state, so it equals (state == S5) glitch-free.
      assign detect = detect_q;
   end

endmodule

// File: rtl/seq10110_detector.sv
// Moore and Mealy 10110 detectors side by side on the same serial input.
module seq10110_detector
   import seq10110_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic j,
   output logic w_moore,
   output logic w_mealy
);

   seq10110_fsm_core #(
      .Style (StyleMoore)
   ) u_moore (
      .clk    (clk),
      .rst    (rst),
      .j      (j),
      .detect (w_moore)
   );

   seq10110_fsm_core #(
      .Style (StyleMealy)
   ) u_mealy (
      .clk    (clk),
      .rst    (rst),
      .j      (j),
      .detect (w_mealy)
   );

endmodule

// File: tb/tb_seq10110_detector.sv
// Scoreboarded random and directed bench for seq10110_detector against a bit-history model.
`timescale 1ns/1ps
module tb_seq10110_detector;
   import seq10110_pkg::*;

   typedef struct packed {
      logic moore;
      logic mealy;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic j   = 1'b0;
   logic w_moore;
   logic w_mealy;

   int   total = 0;
   int   bad   = 0;
   bit   hist[$];
   exp_t sb[$];

   seq10110_detector dut (
      .clk     (clk),
      .rst     (rst),
      .j       (j),
      .w_moore (w_moore),
      .w_mealy (w_mealy)
   );

   always #50 clk = ~clk;

   // True when the last n clocked bits equal the first n bits of the pattern.
   function automatic bit prefix_at_tail(int n);
      logic [4:0] pat;
      pat = PATTERN;
      if (hist.size() < n) return 1'b0;
      for (int k = 0; k < n; k++) begin
         if (hist[hist.size() - n + k] != pat[4 - k]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic check(input string name, input logic act, input logic req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, req);
      end
   endtask

   // Called at posedge+10: present a bit, predict this cycle's outputs, clock it into the model.
   task automatic cycle(input logic b, input logic r);
      exp_t e;
      j = b;
      rst = r;
      e.moore = prefix_at_tail(PATTERN_LEN);
      e.mealy = prefix_at_tail(PATTERN_LEN - 1) && (b == 1'b0);
      sb.push_back(e);
      @(posedge clk);
      if (r) hist.delete();
      else hist.push_back(b);
      #10;
   endtask

   task automatic run_bits(input logic [15:0] bits, input int n);
      for (int k = 0; k < n; k++) cycle(bits[n - 1 - k], 1'b0);
   endtask

   // Monitor: compare every cycle that has a queued expectation, well away from the edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("w_moore", w_moore, e.moore);
            check("w_mealy", w_mealy, e.mealy);
         end
      end
   end

   initial begin
      exp_t e;
      // First reset edge establishes a known state; checks start after it.
      rst = 1'b1;
      j = 1'($urandom_range(0, 1));
      @(posedge clk);
      hist.delete();
      #10;
      cycle(1'($urandom_range(0, 1)), 1'b1);

      run_bits(16'b10110, 5);
      cycle(1'b1, 1'b1);
      run_bits(16'b10110110, 8);
      cycle(1'b1, 1'b1);
      run_bits(16'b101110, 6);
      cycle(1'b1, 1'b1);
      run_bits(16'b100110, 6);
      cycle(1'b1, 1'b1);

      // Mealy glitch: reach 1011, hold j=1 with a 20 ns low pulse mid-cycle.
      run_bits(16'b1011, 4);
      j = 1'b1;
      e.moore = prefix_at_tail(PATTERN_LEN);
      e.mealy = 1'b0;
      sb.push_back(e);
      #60;
      j = 1'b0;
      #10;
      check("glitch_mealy_high", w_mealy, 1'b1);
      check("glitch_moore_low", w_moore, 1'b0);
      #10;
      j = 1'b1;
      #1;
      check("glitch_mealy_low", w_mealy, 1'b0);
      @(posedge clk);
      hist.push_back(1'b1);
      #10;
      // Landing in the "1" state means 0110 now completes a match.
      run_bits(16'b0110, 4);
      cycle(1'b1, 1'b1);

      // Reset mid-sequence, then a lone 0, then a fresh match.
      run_bits(16'b1011, 4);
      cycle(1'b1, 1'b1);
      cycle(1'b0, 1'b0);
      run_bits(16'b10110, 5);

      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0));
      end

      for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
      #1;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
